// File: rtl/bayer_line_buffer.sv
// One-row line buffer for a Bayer stream: presents each pixel with the pixel above it,
// and flags the cycles in which the downstream 2x2 greyscale sum is a complete block.
module bayer_line_buffer #(
   parameter int WIDTH      = 12,
   parameter int LINE_LEN   = 640,
   parameter int FRAME_ROWS = 480,
   localparam int XW = (LINE_LEN   > 2) ? $clog2(LINE_LEN / 2)   : 1,
   localparam int YW = (FRAME_ROWS > 2) ? $clog2(FRAME_ROWS / 2) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_in_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] tap0,
   output logic [WIDTH-1:0] tap1,
   output logic             tap_valid,
   output logic             gs_valid,
   output logic [XW-1:0]    gs_x,
   output logic [YW-1:0]    gs_y
);

   localparam int CW = $clog2(LINE_LEN);
   localparam int RW = $clog2(FRAME_ROWS);

   logic [WIDTH-1:0] mem [LINE_LEN];

   logic [CW-1:0] col, col_cur, tap_col;
   logic [RW-1:0] row, row_cur, tap_row;
   logic          col_last, row_last;
   logic          prev_tap_valid;

   // frame_start overrides the counters for a pixel arriving in the same cycle
   assign col_cur  = frame_start ? '0 : col;
   assign row_cur  = frame_start ? '0 : row;
   assign col_last = (col_cur == CW'(LINE_LEN - 1));
   assign row_last = (row_cur == RW'(FRAME_ROWS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (data_in_valid) begin
         col <= col_last ? '0 : col_cur + 1'b1;
         if (col_last)
            row <= row_last ? '0 : row_cur + 1'b1;
         else
            row <= row_cur;
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
      end
   end

   // Line memory is deliberately not reset; row-0 reads are stale by design
   always_ff @(posedge clk) begin
      if (data_in_valid)
         mem[col_cur] <= data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap0      <= '0;
         tap1      <= '0;
         tap_valid <= 1'b0;
         tap_col   <= '0;
         tap_row   <= '0;
      end else begin
         tap_valid <= data_in_valid;
         if (data_in_valid) begin
            tap0    <= mem[col_cur];
            tap1    <= data_in;
            tap_col <= col_cur;
            tap_row <= row_cur;
         end
      end
   end

   // A block is complete only if its even and odd pixels arrived back to back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_tap_valid <= 1'b0;
         gs_valid       <= 1'b0;
         gs_x           <= '0;
         gs_y           <= '0;
      end else begin
         prev_tap_valid <= tap_valid;
         gs_valid       <= tap_valid & tap_col[0] & tap_row[0] & prev_tap_valid;
         gs_x           <= XW'(tap_col >> 1);
         gs_y           <= YW'(tap_row >> 1);
      end
   end

endmodule

// File: tb/tb_bayer_line_buffer.sv
// Directed bench for bayer_line_buffer on a 4x4 frame, with a two-stage greyscale model.
module tb_bayer_line_buffer;

   localparam int WIDTH = 12;
   localparam int LL    = 4;
   localparam int FR    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             data_in_valid = 1'b0;
   logic             frame_start = 1'b0;
   logic [WIDTH-1:0] tap0, tap1;
   logic             tap_valid, gs_valid;
   logic [0:0]       gs_x, gs_y;

   int vectors = 0;
   int miscompares = 0;
   int step_n = 0;

   int t0_q[$], t1_q[$], gx_q[$], gy_q[$], gd_q[$], gstep_q[$];

   // Greyscale register stage: two pixel pairs, summed and divided by four
   logic [WIDTH-1:0] r1a = '0, r1b = '0, r2a = '0, r2b = '0;

   bayer_line_buffer #(.WIDTH(WIDTH), .LINE_LEN(LL), .FRAME_ROWS(FR)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .frame_start(frame_start), .tap0(tap0), .tap1(tap1), .tap_valid(tap_valid),
      .gs_valid(gs_valid), .gs_x(gs_x), .gs_y(gs_y)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      r1a <= tap0;
      r1b <= tap1;
      r2a <= r1a;
      r2b <= r1b;
   end

   task automatic clear_logs();
      t0_q.delete(); t1_q.delete(); gx_q.delete();
      gy_q.delete(); gd_q.delete(); gstep_q.delete();
      step_n = 0;
   endtask

   task automatic step(input logic v, input int d, input logic fs);
      data_in_valid = v;
      data_in       = WIDTH'(d);
      frame_start   = fs;
      @(posedge clk);
      #1;
      step_n++;
      if (tap_valid) begin
         t0_q.push_back(int'(tap0));
         t1_q.push_back(int'(tap1));
      end
      if (gs_valid) begin
         gx_q.push_back(int'(gs_x));
         gy_q.push_back(int'(gs_y));
         gd_q.push_back((int'(r1a) + int'(r1b) + int'(r2a) + int'(r2b)) >> 2);
         gstep_q.push_back(step_n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      data_in_valid = 1'b0;
      frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in       = WIDTH'($urandom);
         data_in_valid = 1'($urandom);
         frame_start   = 1'($urandom);
         @(posedge clk);
         #1;
         vectors += 6;
         if (tap0 !== '0)      begin miscompares++; $display("FAIL reset tap0 got %h want 0", tap0); end
         if (tap1 !== '0)      begin miscompares++; $display("FAIL reset tap1 got %h want 0", tap1); end
         if (tap_valid !== 0)  begin miscompares++; $display("FAIL reset tap_valid got %b want 0", tap_valid); end
         if (gs_valid !== 0)   begin miscompares++; $display("FAIL reset gs_valid got %b want 0", gs_valid); end
         if (gs_x !== '0)      begin miscompares++; $display("FAIL reset gs_x got %h want 0", gs_x); end
         if (gs_y !== '0)      begin miscompares++; $display("FAIL reset gs_y got %h want 0", gs_y); end
      end
      data_in_valid = 1'b0;
      frame_start = 1'b0;
      #3;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int et0[4] = '{1, 2, 3, 4};
      int et1[4] = '{5, 6, 7, 8};
      int ex[2] = '{0, 1};
      int ed[2] = '{3, 5};
      int es[2] = '{7, 9};
      do_reset();
      clear_logs();
      for (int p = 1; p <= 8; p++) step(1'b1, p, 1'b0);
      repeat (2) step(1'b0, 0, 1'b0);
      vectors++;
      if (t0_q.size() != 8) begin miscompares++; $display("FAIL basic tap_count got %0d want 8", t0_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         vectors++;
         if (t0_q[4+i] !== et0[i] || t1_q[4+i] !== et1[i]) begin
            miscompares++;
            $display("FAIL basic row1_tap%0d got (%0d,%0d) want (%0d,%0d)", i, t0_q[4+i], t1_q[4+i], et0[i], et1[i]);
         end
      end
      vectors++;
      if (gx_q.size() != 2) begin miscompares++; $display("FAIL basic gs_count got %0d want 2", gx_q.size()); end
      else for (int i = 0; i < 2; i++) begin
         vectors++;
         if (gx_q[i] !== ex[i] || gy_q[i] !== 0 || gd_q[i] !== ed[i] || gstep_q[i] !== es[i]) begin
            miscompares++;
            $display("FAIL basic gs%0d got x=%0d y=%0d d=%0d step=%0d want x=%0d y=0 d=%0d step=%0d",
                     i, gx_q[i], gy_q[i], gd_q[i], gstep_q[i], ex[i], ed[i], es[i]);
         end
      end
   endtask

   task automatic test_bubble();
      do_reset();
      clear_logs();
      for (int p = 1; p <= 5; p++) step(1'b1, p, 1'b0);
      step(1'b0, 99, 1'b0);
      for (int p = 6; p <= 8; p++) step(1'b1, p, 1'b0);
      repeat (2) step(1'b0, 0, 1'b0);
      vectors++;
      if (gx_q.size() != 1) begin miscompares++; $display("FAIL bubble gs_count got %0d want 1", gx_q.size()); end
      else begin
         vectors++;
         if (gx_q[0] !== 1 || gy_q[0] !== 0 || gd_q[0] !== 5 || gstep_q[0] !== 10) begin
            miscompares++;
            $display("FAIL bubble gs got x=%0d y=%0d d=%0d step=%0d want x=1 y=0 d=5 step=10",
                     gx_q[0], gy_q[0], gd_q[0], gstep_q[0]);
         end
      end
      vectors++;
      if (t0_q.size() != 8 || t0_q[5] !== 2 || t1_q[5] !== 6) begin
         miscompares++;
         $display("FAIL bubble tap_after_gap got n=%0d want n=8 pair (2,6)", t0_q.size());
      end
   endtask

   task automatic test_frame_start();
      int ex[2] = '{0, 1};
      int ed[2] = '{12, 14};
      int es[2] = '{10, 12};
      do_reset();
      clear_logs();
      for (int p = 1; p <= 3; p++) step(1'b1, p, 1'b0);
      step(1'b1, 10, 1'b1);
      for (int p = 11; p <= 17; p++) step(1'b1, p, 1'b0);
      repeat (2) step(1'b0, 0, 1'b0);
      vectors++;
      if (t0_q.size() != 11 || t0_q[7] !== 10 || t1_q[7] !== 14 || t0_q[10] !== 13 || t1_q[10] !== 17) begin
         miscompares++;
         $display("FAIL fstart row1_taps got n=%0d want n=11 pairs (10,14)..(13,17)", t0_q.size());
      end
      vectors++;
      if (gx_q.size() != 2) begin miscompares++; $display("FAIL fstart gs_count got %0d want 2", gx_q.size()); end
      else for (int i = 0; i < 2; i++) begin
         vectors++;
         if (gx_q[i] !== ex[i] || gy_q[i] !== 0 || gd_q[i] !== ed[i] || gstep_q[i] !== es[i]) begin
            miscompares++;
            $display("FAIL fstart gs%0d got x=%0d y=%0d d=%0d step=%0d want x=%0d y=0 d=%0d step=%0d",
                     i, gx_q[i], gy_q[i], gd_q[i], gstep_q[i], ex[i], ed[i], es[i]);
         end
      end
   endtask

   task automatic test_frame_wrap();
      int ex[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
      int ey[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
      int ed[8] = '{3, 5, 11, 13, 19, 21, 27, 29};
      do_reset();
      clear_logs();
      for (int p = 1; p <= 32; p++) step(1'b1, p, 1'b0);
      repeat (2) step(1'b0, 0, 1'b0);
      vectors++;
      if (gx_q.size() != 8) begin miscompares++; $display("FAIL wrap gs_count got %0d want 8", gx_q.size()); end
      else for (int i = 0; i < 8; i++) begin
         vectors++;
         if (gx_q[i] !== ex[i] || gy_q[i] !== ey[i] || gd_q[i] !== ed[i]) begin
            miscompares++;
            $display("FAIL wrap gs%0d got x=%0d y=%0d d=%0d want x=%0d y=%0d d=%0d",
                     i, gx_q[i], gy_q[i], gd_q[i], ex[i], ey[i], ed[i]);
         end
      end
      vectors++;
      if (t0_q.size() != 32) begin miscompares++; $display("FAIL wrap tap_count got %0d want 32", t0_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         vectors++;
         if (t0_q[16+i] !== 13 + i || t1_q[16+i] !== 17 + i) begin
            miscompares++;
            $display("FAIL wrap f2_row0_tap%0d got (%0d,%0d) want (%0d,%0d)", i, t0_q[16+i], t1_q[16+i], 13 + i, 17 + i);
         end
      end
   endtask

   task automatic test_async_reset();
      int ex[2] = '{0, 1};
      int ed[2] = '{3, 5};
      do_reset();
      clear_logs();
      for (int p = 1; p <= 6; p++) step(1'b1, p, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      vectors += 3;
      if (tap0 !== '0 || tap1 !== '0) begin miscompares++; $display("FAIL areset taps got (%0d,%0d) want (0,0)", tap0, tap1); end
      if (tap_valid !== 0) begin miscompares++; $display("FAIL areset tap_valid got %b want 0", tap_valid); end
      if (gs_valid !== 0 || gs_x !== '0 || gs_y !== '0) begin
         miscompares++;
         $display("FAIL areset gs got v=%b x=%0d y=%0d want 0", gs_valid, gs_x, gs_y);
      end
      #3;
      rst = 1'b1;
      clear_logs();
      for (int p = 1; p <= 8; p++) step(1'b1, p, 1'b0);
      repeat (2) step(1'b0, 0, 1'b0);
      vectors++;
      if (t0_q.size() != 8 || t0_q[4] !== 1 || t1_q[4] !== 5 || t0_q[7] !== 4 || t1_q[7] !== 8) begin
         miscompares++;
         $display("FAIL areset row1_taps got n=%0d want n=8 pairs (1,5)..(4,8)", t0_q.size());
      end
      vectors++;
      if (gx_q.size() != 2) begin miscompares++; $display("FAIL areset gs_count got %0d want 2", gx_q.size()); end
      else for (int i = 0; i < 2; i++) begin
         vectors++;
         if (gx_q[i] !== ex[i] || gy_q[i] !== 0 || gd_q[i] !== ed[i]) begin
            miscompares++;
            $display("FAIL areset gs%0d got x=%0d y=%0d d=%0d want x=%0d y=0 d=%0d",
                     i, gx_q[i], gy_q[i], gd_q[i], ex[i], ed[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubble();
      test_frame_start();
      test_frame_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation exceeded 100000 time units");
      $fatal(1, "timeout");
   end

endmodule
